mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//   Job-level initiator for the uint8 x uint8 -> int32 MAC (clear_acc/enable/data/weight protocol).
//   Accepts one dot-product job, streams N activation/weight byte pairs from two synchronous-read
//   buffers into the MAC, waits out the MAC's 1-cycle accumulate latency, and returns acc_out over a
//   valid/ready result port. Sits between the layer controller (conv1 27, conv2 144, FC 64 MACs) and the MAC.
// PARAMETERS
//   ADDR_W  10  activation/weight buffer address width
//   LEN_W   9   job length width; max N = 2**LEN_W-1
//   DATA_W  8   activation/weight width (unsigned)
//   ACC_W   32  MAC accumulator/result width
// PORTS
//   clock       in   1       system clock
//   reset       in   1       synchronous, active-high
//   start       in   1       job request; accepted when start & start_ready
//   start_ready out  1       high only in IDLE
//   len         in   LEN_W   MAC count N, sampled at acceptance
//   act_base    in   ADDR_W  activation start address, sampled at acceptance
//   wgt_base    in   ADDR_W  weight start address, sampled at acceptance
//   bias_in     in   ACC_W   signed bias, sampled at acceptance (used only with MAC_SEQ_BIAS_EN)
//   act_rd_en   out  1       activation buffer read strobe
//   act_addr    out  ADDR_W  activation read address
//   act_rdata   in   DATA_W  activation data, valid 1 cycle after act_rd_en
//   wgt_rd_en   out  1       weight buffer read strobe
//   wgt_addr    out  ADDR_W  weight read address
//   wgt_rdata   in   DATA_W  weight data, valid 1 cycle after wgt_rd_en
//   mac_clear   out  1       to MAC clear_acc
//   mac_enable  out  1       to MAC enable
//   mac_data    out  DATA_W  to MAC data_in
//   mac_weight  out  DATA_W  to MAC weight_in
//   mac_acc     in   ACC_W   from MAC acc_out
//   res_data    out  ACC_W   dot-product result, stable while res_valid
//   res_valid   out  1       result available; held until res_ready
//   res_ready   in   1       result consumer ready
//   busy        out  1       high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, every output 0 except start_ready=1. Reset mid-job aborts it, no result emitted.
//   - FSM: IDLE -> CLEAR -> STREAM (skipped when N=0) -> DRAIN -> RESULT -> IDLE.
//   - Start accepted at cycle T:
//     - T+1 CLEAR: mac_clear=1; read strobes high with element-0 addresses when N>0.
//     - T+2..T+1+N STREAM: mac_enable=1; mac_data=act_rdata, mac_weight=wgt_rdata (combinational).
//       Element i+1 read issued while i<N-1; addresses = base+i modulo 2**ADDR_W (wrap, no error).
//     - T+2+N DRAIN: no enable; mac_acc captured into res_data at end of cycle.
//     - T+3+N RESULT: res_valid=1. Latency start->res_valid = N+3 (N=0 -> 3, res_data=0).
//   - mac_data/mac_weight forced to 0 whenever mac_enable=0; mac_clear and mac_enable never high together.
//   - RESULT exits on res_valid & res_ready; IDLE is entered the next cycle, so no back-to-back start in that cycle.
//     res_data holds its value until the next capture.
//   - start while busy is ignored, not queued; len/bases/bias changes after acceptance have no effect.
//   - Result is the raw ACC_W MAC value; the sequencer does no overflow detection.
// CONFIGURATION
//   MAC_SEQ_BIAS_EN defined:   res_data = mac_acc + bias_in (ACC_W two's-complement wrap), added at capture; latency unchanged.
//   MAC_SEQ_BIAS_EN undefined: res_data = mac_acc; bias_in is left unconnected internally.
// STRUCTURE
//   - mac_seq_pkg: state enum (IDLE, CLEAR, STREAM, DRAIN, RESULT), default width localparams.
//   - Sub-module mac_seq_addr_gen: element counter plus the two wrapping address registers,
//     with load/advance/last outputs; the FSM and result register stay in mac_dot_sequencer.
// TESTING
//   1. len=1, act[0]=42, wgt[0]=12 -> res_valid at T+4, res_data=504.
//   2. len=144, all act=2, all wgt=3 -> mac_enable high exactly 144 cycles; res_data=864 at T+147.
//   3. len=0 -> no read strobes, no mac_enable; res_valid at T+3 with res_data=0.
//   4. act_base=wgt_base=1023, len=2, act={5,6}, wgt={1,1} -> addresses 1023 then 0; res_data=11.
//   5. res_ready low 5 cycles in RESULT -> res_valid/res_data stable; start pulses ignored; start_ready=0.
//   6. Reset at STREAM element 10 of len=27 -> all outputs 0 next cycle, no res_valid; then len=1 job (42,12) returns 504.
//   7. With MAC_SEQ_BIAS_EN: job of test 1 with bias_in=-500 -> res_data=4.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_seq_pkg;

    localparam int MAC_SEQ_ADDR_W = 10;
    localparam int MAC_SEQ_LEN_W  = 9;
    localparam int MAC_SEQ_DATA_W = 8;
    localparam int MAC_SEQ_ACC_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } seq_state_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Element counter and wrapping activation/weight read-address registers for one job.
module mac_seq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 9
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              rd_adv_i,
    input  logic              elem_adv_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] act_base_i,
    input  logic [ADDR_W-1:0] wgt_base_i,
    output logic [ADDR_W-1:0] act_addr_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    output logic              empty_o,
    output logic              last_o
);

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] act_addr_q, act_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            len_q      <= '0;
            cnt_q      <= '0;
            act_addr_q <= '0;
            wgt_addr_q <= '0;
        end else begin
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            act_addr_q <= act_addr_d;
            wgt_addr_q <= wgt_addr_d;
        end
    end

    // Addresses step once per issued read; the counter steps once per streamed element.
    always_comb begin
        len_d      = len_q;
        cnt_d      = cnt_q;
        act_addr_d = act_addr_q;
        wgt_addr_d = wgt_addr_q;
        if (load_i) begin
            len_d      = len_i;
            cnt_d      = '0;
            act_addr_d = act_base_i;
            wgt_addr_d = wgt_base_i;
        end else begin
            if (rd_adv_i) begin
                act_addr_d = act_addr_q + ADDR_W'(1);
                wgt_addr_d = wgt_addr_q + ADDR_W'(1);
            end
            if (elem_adv_i) begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    assign act_addr_o = act_addr_q;
    assign wgt_addr_o = wgt_addr_q;
    assign empty_o    = (len_q == '0);
    assign last_o     = (cnt_q == len_q - LEN_W'(1));

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job-level sequencer feeding a uint8 MAC from two synchronous-read buffers.
// Optional MAC_SEQ_BIAS_EN adds a signed bias to the result at capture.
//   state  | meaning
//   IDLE   | waiting for start, start_ready high
//   CLEAR  | clear MAC accumulator, issue element-0 reads
//   STREAM | one MAC enable per element, prefetch next element
//   DRAIN  | wait out MAC latency, capture result
//   RESULT | res_valid high until res_ready
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int ADDR_W = MAC_SEQ_ADDR_W,
    parameter int LEN_W  = MAC_SEQ_LEN_W,
    parameter int DATA_W = MAC_SEQ_DATA_W,
    parameter int ACC_W  = MAC_SEQ_ACC_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              start_ready_o,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] act_base_i,
    input  logic [ADDR_W-1:0] wgt_base_i,
    input  logic [ACC_W-1:0]  bias_i,
    output logic              act_rd_en_o,
    output logic [ADDR_W-1:0] act_addr_o,
    input  logic [DATA_W-1:0] act_rdata_i,
    output logic              wgt_rd_en_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    input  logic [DATA_W-1:0] wgt_rdata_i,
    output logic              mac_clear_o,
    output logic              mac_enable_o,
    output logic [DATA_W-1:0] mac_data_o,
    output logic [DATA_W-1:0] mac_weight_o,
    input  logic [ACC_W-1:0]  mac_acc_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o
);

    seq_state_t        state_q, state_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic              load, rd_en, elem_adv, capture, mac_clear, mac_en;
    logic              empty, last;
    logic [ADDR_W-1:0] act_addr, wgt_addr;
    logic [ACC_W-1:0]  capture_val;

    mac_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .rd_adv_i   (rd_en),
        .elem_adv_i (elem_adv),
        .len_i      (len_i),
        .act_base_i (act_base_i),
        .wgt_base_i (wgt_base_i),
        .act_addr_o (act_addr),
        .wgt_addr_o (wgt_addr),
        .empty_o    (empty),
        .last_o     (last)
    );

`ifdef MAC_SEQ_BIAS_EN
    logic [ACC_W-1:0] bias_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            bias_q <= '0;
        end else if (load) begin
            bias_q <= bias_i;
        end
    end

    assign capture_val = mac_acc_i + bias_q;
`else
    logic unused_bias;
    assign unused_bias = ^bias_i;
    assign capture_val = mac_acc_i;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        rd_en     = 1'b0;
        elem_adv  = 1'b0;
        capture   = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clear = 1'b1;
                if (empty) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en   = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                mac_en   = 1'b1;
                elem_adv = 1'b1;
                if (last) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                capture = 1'b1;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign res_d = capture ? capture_val : res_q;

    // Addresses are gated so the bus reads zero whenever no read is issued.
    assign act_rd_en_o   = rd_en;
    assign wgt_rd_en_o   = rd_en;
    assign act_addr_o    = rd_en ? act_addr : '0;
    assign wgt_addr_o    = rd_en ? wgt_addr : '0;
    assign mac_clear_o   = mac_clear;
    assign mac_enable_o  = mac_en;
    assign mac_data_o    = mac_en ? act_rdata_i : '0;
    assign mac_weight_o  = mac_en ? wgt_rdata_i : '0;
    assign res_data_o    = res_q;
    assign res_valid_o   = (state_q == ST_RESULT);
    assign start_ready_o = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench: buffer and MAC models, directed and random jobs, decoupled monitor.
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start_ready;
    logic [8:0]  len;
    logic [9:0]  act_base, wgt_base;
    logic [31:0] bias_in;
    logic        act_rd_en, wgt_rd_en;
    logic [9:0]  act_addr, wgt_addr;
    logic [7:0]  act_rdata, wgt_rdata;
    logic        mac_clear, mac_enable;
    logic [7:0]  mac_data, mac_weight;
    logic [31:0] mac_acc;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    always #5 clk = ~clk;

    mac_dot_sequencer dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .start_i       (start),
        .start_ready_o (start_ready),
        .len_i         (len),
        .act_base_i    (act_base),
        .wgt_base_i    (wgt_base),
        .bias_i        (bias_in),
        .act_rd_en_o   (act_rd_en),
        .act_addr_o    (act_addr),
        .act_rdata_i   (act_rdata),
        .wgt_rd_en_o   (wgt_rd_en),
        .wgt_addr_o    (wgt_addr),
        .wgt_rdata_i   (wgt_rdata),
        .mac_clear_o   (mac_clear),
        .mac_enable_o  (mac_enable),
        .mac_data_o    (mac_data),
        .mac_weight_o  (mac_weight),
        .mac_acc_i     (mac_acc),
        .res_data_o    (res_data),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .busy_o        (busy)
    );

    logic [7:0] act_mem [1024];
    logic [7:0] wgt_mem [1024];

    always @(posedge clk) begin
        if (act_rd_en) act_rdata <= act_mem[act_addr];
        if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr];
    end

    always @(posedge clk) begin
        if (reset || mac_clear) mac_acc <= 32'd0;
        else if (mac_enable)    mac_acc <= mac_acc + ({24'd0, mac_data} * {24'd0, mac_weight});
    end

    typedef struct {
        logic [31:0] data;
        int          len;
        int          acc_cyc;
    } res_t;

    res_t       res_q [$];
    logic [9:0] exp_act_addr [$];
    logic [9:0] exp_wgt_addr [$];
    logic [7:0] exp_a [$];
    logic [7:0] exp_w [$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          clr_cyc = -1;
    logic        prev_hold = 1'b0;
    logic [31:0] held_exp = 32'd0;
    logic        hold_low = 1'b0;
    res_t        mon_r;
    logic [9:0]  mon_a, mon_w;
    logic [7:0]  mon_d, mon_k;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("clear_and_enable", {31'd0, mac_clear & mac_enable}, 32'd0);
            if (!mac_enable) chk("idle_mac_operands", {16'd0, mac_data, mac_weight}, 32'd0);
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~start_ready});
            if (act_rd_en || wgt_rd_en) begin
                if (exp_act_addr.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    mon_a = exp_act_addr.pop_front();
                    mon_w = exp_wgt_addr.pop_front();
                    chk("read_strobes", {30'd0, act_rd_en, wgt_rd_en}, 32'd3);
                    chk("act_addr", {22'd0, act_addr}, {22'd0, mon_a});
                    chk("wgt_addr", {22'd0, wgt_addr}, {22'd0, mon_w});
                end
            end
            if (mac_enable) begin
                en_cnt++;
                if (exp_a.size() == 0) begin
                    chk("unexpected_enable", 32'd1, 32'd0);
                end else begin
                    mon_d = exp_a.pop_front();
                    mon_k = exp_w.pop_front();
                    chk("mac_operands", {16'd0, mac_data, mac_weight}, {16'd0, mon_d, mon_k});
                end
            end
            if (mac_clear) clr_cyc = cyc;
            if (res_valid && !prev_hold) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_r = res_q.pop_front();
                    chk("res_data", res_data, mon_r.data);
                    chk("latency", 32'(cyc - mon_r.acc_cyc), 32'(mon_r.len + 3));
                    chk("enable_cycles", 32'(en_cnt), 32'(mon_r.len));
                    chk("clear_cycle", 32'(clr_cyc - mon_r.acc_cyc), 32'd1);
                    held_exp = mon_r.data;
                end
                en_cnt = 0;
            end else if (res_valid) begin
                chk("res_data_stable", res_data, held_exp);
            end
            prev_hold = res_valid && !res_ready;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {30'd0, act_rd_en, wgt_rd_en}, 32'd0);
        chk("rst_addr", {12'd0, act_addr, wgt_addr}, 32'd0);
        chk("rst_mac_ctl", {30'd0, mac_clear, mac_enable}, 32'd0);
        chk("rst_mac_operands", {16'd0, mac_data, mac_weight}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
    endtask

    task automatic run_job(input int n, input int ab, input int wb, input logic [31:0] bias);
        int          budget;
        res_t        r;
        logic [31:0] sum;
        logic [9:0]  aa, wa;
        budget = 0;
        sum    = 32'd0;
        @(negedge clk);
        while (!start_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!start_ready) begin
            chk("start_ready_timeout", 32'd0, 32'd1);
            return;
        end
        start    = 1'b1;
        len      = 9'(n);
        act_base = 10'(ab);
        wgt_base = 10'(wb);
        bias_in  = bias;
        for (int i = 0; i < n; i++) begin
            aa = 10'((ab + i) % 1024);
            wa = 10'((wb + i) % 1024);
            exp_act_addr.push_back(aa);
            exp_wgt_addr.push_back(wa);
            exp_a.push_back(act_mem[aa]);
            exp_w.push_back(wgt_mem[wa]);
            sum = sum + 32'(int'(act_mem[aa]) * int'(wgt_mem[wa]));
        end
`ifdef MAC_SEQ_BIAS_EN
        sum = sum + bias;
`endif
        r.data    = sum;
        r.len     = n;
        r.acc_cyc = cyc;
        res_q.push_back(r);
        @(negedge clk);
        start    = 1'b0;
        len      = 9'($urandom);
        act_base = 10'($urandom);
        wgt_base = 10'($urandom);
        bias_in  = $urandom;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!(res_q.size() == 0 && start_ready) && budget < 800) begin
            @(negedge clk);
            budget++;
        end
        chk("job_done_timeout", {31'd0, (res_q.size() == 0 && start_ready)}, 32'd1);
    endtask

    initial begin
        int n, budget;
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        act_base = '0;
        wgt_base = '0;
        bias_in  = '0;
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = 8'($urandom);
            wgt_mem[i] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // single element
        act_mem[0] = 8'd42;
        wgt_mem[0] = 8'd12;
        run_job(1, 0, 0, 32'd0);
        wait_done();

        // conv2-sized job
        for (int i = 0; i < 144; i++) begin
            act_mem[100 + i] = 8'd2;
            wgt_mem[500 + i] = 8'd3;
        end
        run_job(144, 100, 500, 32'd0);
        wait_done();

        // empty job
        run_job(0, 7, 9, 32'd0);
        wait_done();

        // address wrap
        act_mem[1023] = 8'd5;
        act_mem[0]    = 8'd6;
        wgt_mem[1023] = 8'd1;
        wgt_mem[0]    = 8'd1;
        run_job(2, 1023, 1023, 32'd0);
        wait_done();

        // consumer stall with ignored start pulses
        hold_low = 1'b1;
        run_job(3, 200, 300, 32'd0);
        budget = 0;
        while (!res_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("stall_valid_seen", {31'd0, res_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b1;
            len   = 9'($urandom_range(1, 20));
            chk("stall_start_ready", {31'd0, start_ready}, 32'd0);
            chk("stall_valid_held", {31'd0, res_valid}, 32'd1);
        end
        @(negedge clk);
        start    = 1'b0;
        hold_low = 1'b0;
        wait_done();

        // reset mid-stream
        act_mem[0] = 8'd42;
        wgt_mem[0] = 8'd12;
        run_job(27, 400, 600, 32'd0);
        budget = 0;
        while (en_cnt < 10 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_element_10", 32'(en_cnt), 32'd10);
        reset = 1'b1;
        @(negedge clk);
        res_q.delete();
        exp_act_addr.delete();
        exp_wgt_addr.delete();
        exp_a.delete();
        exp_w.delete();
        en_cnt    = 0;
        prev_hold = 1'b0;
        check_reset_outputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_result_after_abort", {31'd0, res_valid}, 32'd0);
        run_job(1, 0, 0, 32'd0);
        wait_done();

        // bias job (bias only applied in the biased build)
        run_job(1, 0, 0, -32'sd500);
        wait_done();

        for (int j = 0; j < 12; j++) begin
            case ($urandom_range(0, 5))
                0: n = 27;
                1: n = 64;
                2: n = 0;
                default: n = int'($urandom_range(1, 40));
            endcase
            run_job(n, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), $urandom);
            wait_done();
        end

        chk("leftover_results", 32'(res_q.size()), 32'd0);
        chk("leftover_reads", 32'(exp_act_addr.size()), 32'd0);
        chk("leftover_elements", 32'(exp_a.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
